board_ram_arbiter: RTL and testbench

- Shares the single-port synchronous board RAM holding the snake game grid (32x24 cells, 2-bit cell codes) between two requesters.
- Requester 1 is the pixel-pipeline renderer, which has priority and a fixed read latency.
- Requester 2 is the game-logic FSM, which uses a req/ack handshake for reads and writes.
- A starvation guard lets a blocked game access through during continuous active video. The renderer is then served stale data for that one slot.

---
 rtl/board_ram_arbiter.sv | 156 +++++++++++++++
 tb/tb_board_ram_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_ram_arbiter.sv
// -----------------------------------------------------------------------------
// board_ram_arbiter
//
// Shares the single-port synchronous board RAM (snake grid, 32x24 cells of
// 2-bit codes) between the pixel renderer and the game-logic FSM.
//
// The renderer has priority and sees a fixed two-cycle read latency. The game
// port uses a req/ack handshake. If a game request is blocked for MAX_WAIT
// consecutive cycles, it pre-empts one render slot. That slot is then answered
// with the last good render value and flagged stale.
//
// Ports
//   pclk, rst                  pixel clock, synchronous active-high reset
//   render_en/render_addr      renderer read request
//   render_data/valid/stale    renderer response, two cycles after render_en
//   game_req/we/addr/wdata     game request, held until game_ack
//   game_ack                   pulse: game access presented to RAM this cycle
//   game_rdata/game_rvalid     game read response, one cycle after game_ack
//   mem_en/we/addr/wdata       registered RAM command
//   mem_rdata                  RAM read data, one cycle after a read command
// -----------------------------------------------------------------------------
module board_ram_arbiter #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 2,
    parameter int MAX_WAIT = 8
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic              render_en,
    input  logic [ADDR_W-1:0] render_addr,
    output logic [DATA_W-1:0] render_data,
    output logic              render_valid,
    output logic              render_stale,
    input  logic              game_req,
    input  logic              game_we,
    input  logic [ADDR_W-1:0] game_addr,
    input  logic [DATA_W-1:0] game_wdata,
    output logic              game_ack,
    output logic [DATA_W-1:0] game_rdata,
    output logic              game_rvalid,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Two-stage slot tracker: grant decision -> RAM command -> RAM data.
    localparam int PIPE_DEPTH = 2;

    // Slot flag bit positions.
    localparam int F_RENDER  = 0;  // renderer asked for this slot
    localparam int F_GRANTED = 1;  // renderer actually got the RAM
    localparam int F_GREAD   = 2;  // slot carries a game read

    logic [7:0]        wait_cnt_reg;
    logic [7:0]        wait_cnt_next;
    logic              game_ack_reg;
    logic              mem_en_reg;
    logic              mem_we_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [DATA_W-1:0] mem_wdata_reg;
    logic [DATA_W-1:0] last_good_reg;

    logic              game_pending;
    logic              override;
    logic              grant_game;
    logic              grant_render;
    logic [2:0]        slot_next;
    logic [2:0]        slot_out;

    // While game_ack is high, the requester has not yet had a chance to drop
    // game_req. Ignoring the request in that cycle prevents a double grant.
    assign game_pending = game_req && !game_ack_reg;
    assign override     = game_pending && (wait_cnt_reg >= 8'(MAX_WAIT));
    assign grant_game   = override || (game_pending && !render_en);
    assign grant_render = render_en && !override;

    // A pending request that does not win counts toward the override.
    // The count saturates at 255.
    always_comb begin
        wait_cnt_next = wait_cnt_reg;
        if (!game_req || grant_game) begin
            wait_cnt_next = '0;
        end else if (game_pending && (wait_cnt_reg != 8'hFF)) begin
            wait_cnt_next = wait_cnt_reg + 8'd1;
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            wait_cnt_reg  <= '0;
            game_ack_reg  <= 1'b0;
            mem_en_reg    <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
        end else begin
            wait_cnt_reg  <= wait_cnt_next;
            game_ack_reg  <= grant_game;
            mem_en_reg    <= grant_game || grant_render;
            mem_we_reg    <= grant_game && game_we;
            mem_addr_reg  <= grant_game ? game_addr : render_addr;
            mem_wdata_reg <= grant_game ? game_wdata : '0;
        end
    end

    // Every render request travels down the pipe whether or not it won the
    // RAM. This guarantees a response exactly two cycles later.
    assign slot_next = {grant_game && !game_we, grant_render, render_en};

    genvar gi;
    generate
        for (gi = 0; gi < PIPE_DEPTH; gi++) begin : g_pipe
            logic [2:0] stage_reg;
            if (gi == 0) begin : g_head
                always_ff @(posedge pclk) begin
                    if (rst) stage_reg <= '0;
                    else     stage_reg <= slot_next;
                end
            end else begin : g_tail
                always_ff @(posedge pclk) begin
                    if (rst) stage_reg <= '0;
                    else     stage_reg <= g_pipe[gi-1].stage_reg;
                end
            end
        end
    endgenerate

    assign slot_out = g_pipe[PIPE_DEPTH-1].stage_reg;

    // Hold the most recent genuine render result so a pre-empted slot can
    // repeat it.
    always_ff @(posedge pclk) begin
        if (rst) begin
            last_good_reg <= '0;
        end else if (slot_out[F_RENDER] && slot_out[F_GRANTED]) begin
            last_good_reg <= mem_rdata;
        end
    end

    assign render_valid = slot_out[F_RENDER];
    assign render_stale = slot_out[F_RENDER] && !slot_out[F_GRANTED];
    assign render_data  = !slot_out[F_RENDER]  ? '0 :
                          slot_out[F_GRANTED]  ? mem_rdata : last_good_reg;

    assign game_rvalid  = slot_out[F_GREAD];
    assign game_rdata   = slot_out[F_GREAD] ? mem_rdata : '0;
    assign game_ack     = game_ack_reg;

    assign mem_en       = mem_en_reg;
    assign mem_we       = mem_we_reg;
    assign mem_addr     = mem_addr_reg;
    assign mem_wdata    = mem_wdata_reg;

endmodule

// File: tb/tb_board_ram_arbiter.sv
// -----------------------------------------------------------------------------
// Directed bench for board_ram_arbiter.
// Behavioural single-port RAM. A cell that was never written reads (addr+1)%4.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_board_ram_arbiter;

    logic       pclk = 1'b0;
    logic       rst  = 1'b1;
    logic       render_en = 1'b0;
    logic [9:0] render_addr = '0;
    logic [1:0] render_data;
    logic       render_valid;
    logic       render_stale;
    logic       game_req = 1'b0;
    logic       game_we = 1'b0;
    logic [9:0] game_addr = '0;
    logic [1:0] game_wdata = '0;
    logic       game_ack;
    logic [1:0] game_rdata;
    logic       game_rvalid;
    logic       mem_en;
    logic       mem_we;
    logic [9:0] mem_addr;
    logic [1:0] mem_wdata;
    logic [1:0] mem_rdata = '0;

    logic [1:0] ram [1024];
    logic       ram_written [1024];

    int total = 0;
    int bad   = 0;

    board_ram_arbiter #(.ADDR_W(10), .DATA_W(2), .MAX_WAIT(8)) dut (
        .pclk        (pclk),
        .rst         (rst),
        .render_en   (render_en),
        .render_addr (render_addr),
        .render_data (render_data),
        .render_valid(render_valid),
        .render_stale(render_stale),
        .game_req    (game_req),
        .game_we     (game_we),
        .game_addr   (game_addr),
        .game_wdata  (game_wdata),
        .game_ack    (game_ack),
        .game_rdata  (game_rdata),
        .game_rvalid (game_rvalid),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    always #5 pclk = ~pclk;

    // Board RAM model: the power-up pattern applies until a cell is written.
    always @(posedge pclk) begin
        if (mem_en) begin
            if (mem_we) begin
                ram[mem_addr]         <= mem_wdata;
                ram_written[mem_addr] <= 1'b1;
            end else begin
                mem_rdata <= (ram_written[mem_addr] === 1'b1) ? ram[mem_addr]
                                                              : 2'(int'(mem_addr) + 1);
            end
        end
    end

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic drive_idle();
        render_en   = 1'b0;
        render_addr = '0;
        game_req    = 1'b0;
        game_we     = 1'b0;
        game_addr   = '0;
        game_wdata  = '0;
    endtask

    task automatic test_reset();
        logic [26:0] all_out;
        rst = 1'b1;
        render_en = 1'b1; render_addr = 10'd5;
        game_req = 1'b1; game_we = 1'b1; game_addr = 10'd7; game_wdata = 2'd2;
        for (int i = 0; i < 5; i++) begin
            step();
            all_out = {render_data, render_valid, render_stale, game_ack, game_rdata,
                       game_rvalid, mem_en, mem_we, mem_addr, mem_wdata, 4'b0};
            total++;
            if (all_out !== '0) begin
                $display("FAIL reset_outputs cycle=%0d got=%h want=0", i, all_out);
                bad++;
            end
        end
        rst = 1'b0;
        game_req = 1'b0;
        total++;
        if (mem_en !== 1'b0) begin
            $display("FAIL reset_first_cycle mem_en got=%b want=0", mem_en);
            bad++;
        end
        step();
        render_en = 1'b0;
        total++;
        if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 10'd5}) begin
            $display("FAIL reset_second_cycle en/we/addr got=%b/%b/%0d want=1/0/5",
                     mem_en, mem_we, mem_addr);
            bad++;
        end
        repeat (4) step();
    endtask

    task automatic test_render_stream();
        for (int i = 0; i < 13; i++) begin
            total++;
            if (render_valid !== (i >= 2 && i < 12)) begin
                $display("FAIL render_valid cycle=%0d got=%b", i, render_valid);
                bad++;
            end
            if (i >= 2 && i < 12) begin
                total++;
                if (render_data !== 2'(i - 1) || render_stale !== 1'b0) begin
                    $display("FAIL render_data cycle=%0d got=%0d/stale=%b want=%0d/0",
                             i, render_data, render_stale, (i - 1) % 4);
                    bad++;
                end
            end
            render_en   = (i < 10);
            render_addr = 10'(i);
            step();
        end
        drive_idle();
        repeat (3) step();
    endtask

    task automatic test_back_to_back();
        game_req = 1'b1; game_we = 1'b1; game_addr = 10'd37; game_wdata = 2'd3;
        step();
        total++;
        if ({game_ack, mem_en, mem_we, mem_addr, mem_wdata} !== {3'b111, 10'd37, 2'd3}) begin
            $display("FAIL game_write_issue ack/en/we/addr/wd got=%b/%b/%b/%0d/%0d want=1/1/1/37/3",
                     game_ack, mem_en, mem_we, mem_addr, mem_wdata);
            bad++;
        end
        game_we = 1'b0; game_wdata = 2'd0;
        step();
        total++;
        if (game_ack !== 1'b0 || mem_en !== 1'b0 || game_rvalid !== 1'b0) begin
            $display("FAIL game_ack_gap ack/en/rvalid got=%b/%b/%b want=0/0/0",
                     game_ack, mem_en, game_rvalid);
            bad++;
        end
        step();
        total++;
        if ({game_ack, mem_en, mem_we, mem_addr} !== {3'b110, 10'd37}) begin
            $display("FAIL game_read_issue ack/en/we/addr got=%b/%b/%b/%0d want=1/1/0/37",
                     game_ack, mem_en, mem_we, mem_addr);
            bad++;
        end
        game_req = 1'b0;
        step();
        total++;
        if (game_rvalid !== 1'b1 || game_rdata !== 2'd3) begin
            $display("FAIL game_read_data rvalid/data got=%b/%0d want=1/3", game_rvalid, game_rdata);
            bad++;
        end
        step();
        total++;
        if (game_rvalid !== 1'b0 || game_ack !== 1'b0) begin
            $display("FAIL game_read_done rvalid/ack got=%b/%b want=0/0", game_rvalid, game_ack);
            bad++;
        end
        drive_idle();
        repeat (3) step();
    endtask

    // Continuous rendering: the game read must win via the override exactly
    // MAX_WAIT cycles after the request appears.
    task automatic test_starvation();
        logic acked = 1'b0;
        for (int i = 0; i < 13; i++) begin
            total++;
            if (game_ack !== (i == 9)) begin
                $display("FAIL starve_ack cycle=%0d got=%b want=%b", i, game_ack, i == 9);
                bad++;
            end
            total++;
            if (render_valid !== (i >= 2) || render_stale !== (i == 10)) begin
                $display("FAIL starve_render_flags cycle=%0d valid/stale got=%b/%b", i,
                         render_valid, render_stale);
                bad++;
            end
            if (i >= 2) begin
                total++;
                if (render_data !== ((i == 10) ? 2'd1 : 2'(i))) begin
                    $display("FAIL starve_render_data cycle=%0d got=%0d want=%0d", i, render_data,
                             (i == 10) ? 1 : i % 4);
                    bad++;
                end
            end
            total++;
            if (game_rvalid !== (i == 10) || (i == 10 && game_rdata !== 2'd3)) begin
                $display("FAIL starve_game_read cycle=%0d rvalid/data got=%b/%0d want=%b/3", i,
                         game_rvalid, game_rdata, i == 10);
                bad++;
            end
            if (game_ack === 1'b1) acked = 1'b1;
            game_req    = !acked;
            game_we     = 1'b0;
            game_addr   = 10'd102;
            render_en   = (i <= 10);
            render_addr = 10'(i + 1);
            step();
        end
        drive_idle();
        repeat (3) step();
    endtask

    task automatic test_gap_grant();
        int pat [8] = '{1, 1, 1, 0, 1, 1, 0, 0};
        logic acked = 1'b0;
        logic exp_valid;
        for (int i = 0; i < 10; i++) begin
            exp_valid = 1'b0;
            if (i >= 2) exp_valid = (pat[i-2] == 1);
            total++;
            if (game_ack !== (i == 4)) begin
                $display("FAIL gap_ack cycle=%0d got=%b want=%b", i, game_ack, i == 4);
                bad++;
            end
            total++;
            if (render_valid !== exp_valid || render_stale !== 1'b0 || game_rvalid !== 1'b0) begin
                $display("FAIL gap_flags cycle=%0d valid/stale/rvalid got=%b/%b/%b want=%b/0/0",
                         i, render_valid, render_stale, game_rvalid, exp_valid);
                bad++;
            end
            if (exp_valid) begin
                total++;
                if (render_data !== 2'(i + 2)) begin
                    $display("FAIL gap_data cycle=%0d got=%0d want=%0d", i, render_data, (i + 2) % 4);
                    bad++;
                end
            end
            if (game_ack === 1'b1) acked = 1'b1;
            game_req    = !acked;
            game_we     = 1'b1;
            game_addr   = 10'd200;
            game_wdata  = 2'd2;
            render_en   = (i < 8) ? (pat[i] == 1) : 1'b0;
            render_addr = 10'(i + 3);
            step();
        end
        drive_idle();
        step();
        total++;
        if (ram[200] !== 2'd2) begin
            $display("FAIL gap_write_ram got=%0d want=2", ram[200]);
            bad++;
        end
        repeat (2) step();
    endtask

    task automatic test_reset_abort();
        logic acked = 1'b0;
        render_en = 1'b1; render_addr = 10'd4;
        step();
        render_en = 1'b0;
        game_req = 1'b1; game_we = 1'b0; game_addr = 10'd102;
        rst = 1'b1;
        step();
        game_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (game_ack !== 1'b0 || game_rvalid !== 1'b0 || render_valid !== 1'b0) begin
                $display("FAIL abort_quiet cycle=%0d ack/rvalid/valid got=%b/%b/%b want=0/0/0",
                         i, game_ack, game_rvalid, render_valid);
                bad++;
            end
            if (i == 1) rst = 1'b0;
            step();
        end
        // The override timing after reset shows the wait counter restarting from zero.
        for (int i = 0; i < 12; i++) begin
            total++;
            if (game_ack !== (i == 9)) begin
                $display("FAIL abort_restart_ack cycle=%0d got=%b want=%b", i, game_ack, i == 9);
                bad++;
            end
            if (game_ack === 1'b1) acked = 1'b1;
            game_req    = !acked;
            game_we     = 1'b0;
            game_addr   = 10'd50;
            render_en   = 1'b1;
            render_addr = 10'(i);
            step();
        end
        drive_idle();
        repeat (3) step();
    endtask

    initial begin
        #1;
        test_reset();
        test_render_stream();
        test_back_to_back();
        test_starvation();
        test_gap_grant();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
